// File: rtl/data_ram_arb_pkg.sv
// Shared types and helpers for the data RAM arbiter: FSM states, strobe
// constants and the byte-merge used by read-modify-write.
package data_ram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR,
        DONE
    } state_t;

    localparam logic [3:0] STRB_FULL = 4'hF;
    localparam logic [3:0] STRB_NONE = 4'h0;

    // Bytes with strb set come from new_word, the rest keep old_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        for (int i = 0; i < 4; i++) begin
            result[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/data_ram_arb_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port RAM.
interface data_ram_arb_if;

    logic        m0_req;
    logic [31:0] m0_addr;
    logic        m0_we;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_wstrb;
    logic [31:0] m0_rdata;
    logic        m0_ack;

    logic        m1_req;
    logic [31:0] m1_addr;
    logic        m1_we;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_wstrb;
    logic [31:0] m1_rdata;
    logic        m1_ack;

    logic [31:0] ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_rdata_valid;

    // Arbiter side.
    modport slave (
        input  m0_req, m0_addr, m0_we, m0_wdata, m0_wstrb,
        output m0_rdata, m0_ack,
        input  m1_req, m1_addr, m1_we, m1_wdata, m1_wstrb,
        output m1_rdata, m1_ack,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata, ram_rdata_valid
    );

    // Requesters and RAM side.
    modport master (
        output m0_req, m0_addr, m0_we, m0_wdata, m0_wstrb,
        input  m0_rdata, m0_ack,
        output m1_req, m1_addr, m1_we, m1_wdata, m1_wstrb,
        input  m1_rdata, m1_ack,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata, ram_rdata_valid
    );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-requester round-robin picker; on a tie the port that
// was not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_served,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_served ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/data_ram_arbiter.sv
// Two-port round-robin sequencer for the single-port data RAM, turning
// partial-strobe writes into read-modify-write sequences.
module data_ram_arbiter
    import data_ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input logic           clk,
    input logic           reset,
    data_ram_arb_if.slave bus
);

    state_t                state, next_state;
    logic [1:0]            grant;
    logic                  sel;
    logic [31:0]           in_addr, in_wdata;
    logic                  in_we;
    logic [3:0]            in_wstrb;

    logic [ADDR_WIDTH-1:0] addr_q, next_addr;
    logic                  we_q, next_we;
    logic [31:0]           wdata_q, next_wdata;
    logic [3:0]            wstrb_q, next_wstrb;
    logic                  port_q, next_port;
    logic                  last_served, next_last;

    logic [31:0]           ram_addr_q, ram_wdata_q, next_ram_wdata;
    logic                  ram_we_q, next_ram_we;
    logic [31:0]           rd_word;
    logic                  ack0_q, ack1_q, next_ack0, next_ack1;
    logic [31:0]           rdata0_q, rdata1_q, next_rdata0, next_rdata1;
    logic                  unused_addr_bits;

    rr_arb2 u_rr_arb2 (
        .req         ({bus.m1_req, bus.m0_req}),
        .last_served (last_served),
        .grant       (grant)
    );

    assign sel      = grant[1];
    assign in_addr  = sel ? bus.m1_addr  : bus.m0_addr;
    assign in_we    = sel ? bus.m1_we    : bus.m0_we;
    assign in_wdata = sel ? bus.m1_wdata : bus.m0_wdata;
    assign in_wstrb = sel ? bus.m1_wstrb : bus.m0_wstrb;

    assign unused_addr_bits = ^{bus.m0_addr[31:ADDR_WIDTH+2], bus.m0_addr[1:0],
                                bus.m1_addr[31:ADDR_WIDTH+2], bus.m1_addr[1:0]};

    // Every output is registered, so each next_* is the value seen in the
    // state being entered.
    always_comb begin
        next_state     = state;
        next_addr      = addr_q;
        next_we        = we_q;
        next_wdata     = wdata_q;
        next_wstrb     = wstrb_q;
        next_port      = port_q;
        next_last      = last_served;
        next_ram_we    = 1'b0;
        next_ram_wdata = ram_wdata_q;
        rd_word        = '0;
        case (state)
            IDLE: begin
                if (|grant) begin
                    next_addr  = in_addr[ADDR_WIDTH+1:2];
                    next_we    = in_we;
                    next_wdata = in_wdata;
                    next_wstrb = in_wstrb;
                    next_port  = sel;
                    if (!in_we) begin
                        next_state = RD_ISSUE;
                    end else if (in_wstrb == STRB_FULL) begin
                        next_state     = WR;
                        next_ram_we    = 1'b1;
                        next_ram_wdata = in_wdata;
                    end else if (in_wstrb == STRB_NONE) begin
                        next_state = DONE;
                    end else begin
                        next_state = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: next_state = RD_WAIT;
            RD_WAIT: begin
                if (bus.ram_rdata_valid) begin
                    if (!we_q) begin
                        next_state = DONE;
                        rd_word    = bus.ram_rdata;
                    end else begin
                        next_state     = WR;
                        next_ram_we    = 1'b1;
                        next_ram_wdata = merge_bytes(bus.ram_rdata, wdata_q, wstrb_q);
                    end
                end
            end
            WR: next_state = DONE;
            DONE: begin
                next_last  = port_q;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        next_ack0   = (next_state == DONE) && !next_port;
        next_ack1   = (next_state == DONE) &&  next_port;
        next_rdata0 = next_ack0 ? rd_word : '0;
        next_rdata1 = next_ack1 ? rd_word : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_served <= 1'b1;
        end else begin
            state       <= next_state;
            last_served <= next_last;
        end
    end

    // Reset abandons any access in flight, including a pending RAM write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            port_q      <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            addr_q      <= next_addr;
            we_q        <= next_we;
            wdata_q     <= next_wdata;
            wstrb_q     <= next_wstrb;
            port_q      <= next_port;
            ram_addr_q  <= 32'(next_addr) << 2;
            ram_we_q    <= next_ram_we;
            ram_wdata_q <= next_ram_wdata;
            ack0_q      <= next_ack0;
            ack1_q      <= next_ack1;
            rdata0_q    <= next_rdata0;
            rdata1_q    <= next_rdata1;
        end
    end

    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.m0_ack    = ack0_q;
    assign bus.m1_ack    = ack1_q;
    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Self-checking bench for data_ram_arbiter: directed scenarios plus random
// accesses against a word-array model of the RAM contents.
module tb_data_ram_arbiter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    data_ram_arb_if bus ();

    data_ram_arbiter #(.ADDR_WIDTH(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int we_count    = 0;

    logic [31:0] tb_ram    [1024] = '{default: '0};
    logic [31:0] model_mem [1024] = '{default: '0};

    // Behavioural RAM: whole-word write on every cycle ram_we is high.
    always @(posedge clk) begin
        if (bus.ram_we) begin
            tb_ram[bus.ram_addr[11:2]] <= bus.ram_wdata;
            we_count <= we_count + 1;
        end
    end

    function automatic logic [31:0] ref_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
        logic [31:0] result = 0;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) result = result | (new_word & (32'hFF << (8 * i)));
            else         result = result | (old_word & (32'hFF << (8 * i)));
        end
        return result;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic drive_port(input int port, input logic req, input logic [31:0] addr,
                              input logic we, input logic [31:0] wdata, input logic [3:0] wstrb);
        if (port == 0) begin
            bus.m0_req = req; bus.m0_addr = addr; bus.m0_we = we;
            bus.m0_wdata = wdata; bus.m0_wstrb = wstrb;
        end else begin
            bus.m1_req = req; bus.m1_addr = addr; bus.m1_we = we;
            bus.m1_wdata = wdata; bus.m1_wstrb = wstrb;
        end
    endtask

    task automatic check_acks(input string tag, input int port, input logic [31:0] rd);
        check_output({tag, "_m0_ack"},   32'(bus.m0_ack), (port == 0) ? 32'd1 : 32'd0);
        check_output({tag, "_m1_ack"},   32'(bus.m1_ack), (port == 1) ? 32'd1 : 32'd0);
        check_output({tag, "_m0_rdata"}, bus.m0_rdata,    (port == 0) ? rd : 32'd0);
        check_output({tag, "_m1_rdata"}, bus.m1_rdata,    (port == 1) ? rd : 32'd0);
    endtask

    // Runs one access starting at a negedge in an IDLE cycle and returns at
    // the negedge of the next IDLE cycle. RAM returns data lat cycles late.
    task automatic apply_stimulus(input int port, input logic [31:0] addr, input logic we,
                                  input logic [31:0] wdata, input logic [3:0] wstrb,
                                  input int lat);
        logic [31:0] exp_addr = addr & 32'h0000_0FFC;
        int          idx      = int'(addr[11:2]);
        logic [31:0] merged;
        drive_port(port, 1'b1, addr, we, wdata, wstrb);
        @(negedge clk);
        if (!we || (wstrb != 4'hF && wstrb != 4'h0)) begin
            check_output("issue_ram_we", 32'(bus.ram_we), 0);
            check_output("issue_ram_addr", bus.ram_addr, exp_addr);
            check_acks("issue", -1, 0);
            for (int w = 0; w < lat; w++) begin
                drive_port(port, 1'b1, $urandom, 1'($urandom_range(0, 1)), $urandom,
                           4'($urandom_range(0, 15)));
                @(negedge clk);
                check_acks("wait", -1, 0);
                check_output("wait_ram_we", 32'(bus.ram_we), 0);
            end
            @(negedge clk);
            bus.ram_rdata_valid = 1'b1;
            bus.ram_rdata       = tb_ram[idx];
            check_acks("valid_cycle", -1, 0);
            @(negedge clk);
            bus.ram_rdata_valid = 1'b0;
            bus.ram_rdata       = $urandom;
            if (!we) begin
                check_acks("read_done", port, model_mem[idx]);
            end else begin
                merged = ref_merge(model_mem[idx], wdata, wstrb);
                model_mem[idx] = merged;
                check_output("rmw_ram_we", 32'(bus.ram_we), 1);
                check_output("rmw_ram_addr", bus.ram_addr, exp_addr);
                check_output("rmw_ram_wdata", bus.ram_wdata, merged);
                check_acks("rmw_wr", -1, 0);
                @(negedge clk);
                check_acks("rmw_done", port, 0);
            end
        end else if (wstrb == 4'hF) begin
            model_mem[idx] = wdata;
            check_output("wr_ram_we", 32'(bus.ram_we), 1);
            check_output("wr_ram_addr", bus.ram_addr, exp_addr);
            check_output("wr_ram_wdata", bus.ram_wdata, wdata);
            check_acks("wr", -1, 0);
            @(negedge clk);
            check_acks("wr_done", port, 0);
            check_output("wr_done_ram_we", 32'(bus.ram_we), 0);
        end else begin
            check_acks("zero_strb_done", port, 0);
            check_output("zero_strb_ram_we", 32'(bus.ram_we), 0);
        end
        drive_port(port, 1'b0, 0, 1'b0, 0, 4'h0);
        @(negedge clk);
    endtask

    initial begin
        int          acks_seen;
        int          expect_port;
        int          budget;
        int          we_before;
        logic [31:0] word;

        reset = 1'b1;
        drive_port(0, 1'b0, 0, 1'b0, 0, 4'h0);
        drive_port(1, 1'b0, 0, 1'b0, 0, 4'h0);
        bus.ram_rdata_valid = 1'b0;
        bus.ram_rdata       = 32'h0;
        repeat (3) @(negedge clk);
        check_output("reset_ram_we", 32'(bus.ram_we), 0);
        check_output("reset_ram_addr", bus.ram_addr, 0);
        check_output("reset_ram_wdata", bus.ram_wdata, 0);
        check_acks("reset", -1, 0);
        reset = 1'b0;
        @(negedge clk);

        // Contention straight after reset: port 0 must win the first tie.
        drive_port(0, 1'b1, 32'h40, 1'b1, 32'hA5A5_0000, 4'hF);
        drive_port(1, 1'b1, 32'h44, 1'b1, 32'h0000_5A5A, 4'hF);
        acks_seen   = 0;
        expect_port = 0;
        budget      = 0;
        while (acks_seen < 6 && budget < 60) begin
            @(negedge clk);
            budget++;
            if (bus.m0_ack || bus.m1_ack) begin
                check_output("contention_port", 32'(bus.m1_ack), expect_port);
                check_output("contention_both", 32'(bus.m0_ack & bus.m1_ack), 0);
                expect_port = 1 - expect_port;
                acks_seen++;
            end
        end
        check_output("contention_ack_count", acks_seen, 6);
        drive_port(0, 1'b0, 0, 1'b0, 0, 4'h0);
        drive_port(1, 1'b0, 0, 1'b0, 0, 4'h0);
        model_mem[16] = 32'hA5A5_0000;
        model_mem[17] = 32'h0000_5A5A;
        @(negedge clk);
        apply_stimulus(1, 32'h40, 1'b0, 0, 4'h0, 0);
        apply_stimulus(0, 32'h44, 1'b0, 0, 4'h0, 1);

        // Full write then read-back on port 0.
        apply_stimulus(0, 32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, 0);
        apply_stimulus(0, 32'h10, 1'b0, 32'h0, 4'h0, 0);
        check_output("model_deadbeef", model_mem[4], 32'hDEAD_BEEF);

        // Partial write on port 1: one RAM write, known merged result.
        apply_stimulus(1, 32'h20, 1'b1, 32'h1122_3344, 4'hF, 0);
        we_before = we_count;
        apply_stimulus(1, 32'h20, 1'b1, 32'hAABB_CCDD, 4'b0101, 2);
        check_output("rmw_write_count", we_count - we_before, 1);
        check_output("rmw_ram_content", tb_ram[8], 32'h11BB_33DD);
        apply_stimulus(0, 32'h20, 1'b0, 32'h0, 4'h0, 0);

        // Zero strobe never touches the RAM.
        we_before = we_count;
        apply_stimulus(1, 32'h20, 1'b1, 32'hFFFF_FFFF, 4'h0, 0);
        check_output("zero_strb_write_count", we_count - we_before, 0);

        // Stray valid in IDLE must not produce an ack.
        bus.ram_rdata_valid = 1'b1;
        bus.ram_rdata       = 32'hBAD0_BAD0;
        @(negedge clk);
        bus.ram_rdata_valid = 1'b0;
        check_acks("stray_valid", -1, 0);
        check_output("stray_ram_we", 32'(bus.ram_we), 0);
        @(negedge clk);
        check_acks("stray_valid_next", -1, 0);
        apply_stimulus(0, 32'h10, 1'b0, 32'h0, 4'h0, 0);

        // Slow RAM with scrambled request inputs during the wait.
        apply_stimulus(1, 32'h20, 1'b0, 32'h0, 4'h0, 5);
        apply_stimulus(0, 32'h10, 1'b1, 32'h0000_7700, 4'b0010, 5);

        // Reset while the RMW write is pending: no write, no ack.
        apply_stimulus(0, 32'h80, 1'b1, 32'h8765_4321, 4'hF, 0);
        drive_port(0, 1'b1, 32'h80, 1'b1, 32'h0F0F_0F0F, 4'b0011);
        @(negedge clk);
        @(negedge clk);
        bus.ram_rdata_valid = 1'b1;
        bus.ram_rdata       = tb_ram[32];
        @(negedge clk);
        bus.ram_rdata_valid = 1'b0;
        check_output("pre_reset_ram_we", 32'(bus.ram_we), 1);
        reset = 1'b1;
        #1;
        check_output("async_reset_ram_we", 32'(bus.ram_we), 0);
        drive_port(0, 1'b0, 0, 1'b0, 0, 4'h0);
        repeat (3) begin
            @(negedge clk);
            check_acks("in_reset", -1, 0);
            check_output("in_reset_ram_we", 32'(bus.ram_we), 0);
        end
        reset = 1'b0;
        @(negedge clk);
        check_acks("after_reset", -1, 0);
        apply_stimulus(0, 32'h80, 1'b0, 32'h0, 4'h0, 0);
        check_output("reset_no_write", tb_ram[32], 32'h8765_4321);

        // Random traffic against the model.
        for (int n = 0; n < 40; n++) begin
            int          port  = $urandom_range(0, 1);
            logic [31:0] addr  = 32'h100 + 32'(4 * $urandom_range(0, 15));
            logic        we    = 1'($urandom_range(0, 1));
            logic [3:0]  wstrb;
            case ($urandom_range(0, 3))
                0:       wstrb = 4'hF;
                1:       wstrb = 4'h0;
                default: wstrb = 4'($urandom_range(1, 14));
            endcase
            word = $urandom;
            apply_stimulus(port, addr, we, word, wstrb, $urandom_range(0, 5));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
